vga_timing_gen: RTL and testbench
=================================

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameter CW, default 11: width of the hcount and vcount outputs; SHALL hold every mode's total minus 1.
REQ-002 Parameter NUM_MODES, default 3: number of entries in the mode table.
REQ-003 Parameter DEFAULT_MODE, default 0: mode index loaded on reset.
REQ-004 Port clk, input, 1: pixel clock; all state SHALL update on its rising edge.
REQ-005 Port rst_n, input, 1: asynchronous active-low reset.
REQ-006 Port en, input, 1: pixel-strobe clock enable; state SHALL advance only on cycles with en=1.
REQ-007 Port mode_sel, input, 2: requested mode index.
REQ-008 Port hcount, output, CW: current pixel column.
REQ-009 Port vcount, output, CW: current line.
REQ-010 Port hsync, output, 1: horizontal sync, active high.
REQ-011 Port vsync, output, 1: vertical sync, active high.
REQ-012 Port hblnk, output, 1: horizontal blanking.
REQ-013 Port vblnk, output, 1: vertical blanking.
REQ-014 Port frame_start, output, 1: one-cycle pulse at the start of each frame.
REQ-015 Port mode_active, output, 2: mode index currently in use.

Function
REQ-016 Mode table, all entries registered:
- Mode 0 = 1024x768: H 1344/1024/1048/1184, V 806/768/771/777.
- Mode 1 = 800x600: H 1056/800/840/968, V 628/600/601/605.
- Mode 2 = 640x480: H 800/640/656/752, V 525/480/490/492.
- Order of each group is total / blank start / sync start / sync end.
- Supplying the matching pixel clock is the system's responsibility.
REQ-017 On a cycle with en=1:
- hcount SHALL increment by 1.
- When hcount = H_TOTAL-1, hcount SHALL wrap to 0 and vcount SHALL increment.
- When vcount = V_TOTAL-1 at that same wrap, vcount SHALL also wrap to 0.
REQ-018 With en=0, all outputs SHALL hold, and frame_start SHALL be 0.
REQ-019 Blank and sync outputs SHALL be registered and cycle-aligned with the counter values they describe:
- hblnk = (hcount >= H_BLANK_START).
- hsync = (H_SYNC_START <= hcount < H_SYNC_END).
- vblnk and vsync use the same rules on vcount with the V values.
REQ-020 frame_start SHALL be 1 for exactly the one enabled cycle in which the counters are (0,0) after a frame wrap; it SHALL NOT pulse on leaving reset.
REQ-021 Mode request latch:
- mode_sel SHALL be sampled every enabled cycle into a pending-mode register.
- A value >= NUM_MODES SHALL be ignored, and the pending mode keeps its previous value.
REQ-022 Mode switch timing:
- The pending mode SHALL become active only at the frame wrap (the same edge that produces frame_start).
- The new mode's timings SHALL apply from counter value (0,0).
- A mid-frame change SHALL never truncate or extend the current frame.
REQ-023 Repeated requests in one frame: if mode_sel changes several times within a frame, the last valid value before the wrap SHALL win.
REQ-024 Requests at the wrap: a request equal to mode_active SHALL be a no-op; a request arriving on the wrap cycle itself SHALL take effect at the following wrap.
REQ-025 mode_active SHALL change in the same cycle as the frame_start pulse.

Reset
REQ-026 While rst_n=0, regardless of clk or en:
- hcount=0, vcount=0.
- hsync=0, vsync=0, hblnk=0, vblnk=0, frame_start=0.
- mode_active=DEFAULT_MODE, pending mode=DEFAULT_MODE.
REQ-027 On reset release, the first enabled cycle SHALL produce hcount=1, vcount=0.
REQ-028 Reset asserted mid-frame or mid-switch SHALL discard any pending request.

Structure
REQ-029 vga_pkg SHALL hold:
- typedef struct vga_timing_t (h_total, h_blank_start, h_sync_start, h_sync_end, v_total, v_blank_start, v_sync_start, v_sync_end).
- localparam vga_timing_t VGA_MODES[NUM_MODES].
- The existing 1024x768 constants, kept as mode 0.
REQ-030 One sub-module, vga_axis_cnt, SHALL be instantiated twice (H and V):
- Parameter CW.
- Inputs: total, blank_start, sync_start, sync_end, step.
- Outputs: count, blnk, sync, wrap.

Verification
REQ-031 Reset then en=1 continuously in mode 0:
- hsync rises at hcount=1048 and falls at 1184.
- hblnk rises at 1024.
- After 1344 enabled cycles, hcount=0 and vcount=1.
REQ-032 Mode 0 full frame: frame_start pulses every 1344*806=1083264 enabled cycles; vsync is high for vcount 771..776.
REQ-033 Mode 0 with mode_sel=1 driven at vcount=300:
- Mode 0 timing persists until the wrap.
- mode_active=1 at the next frame_start.
- The next frame period is 1056*628=663168 cycles.
REQ-034 en toggled 1,0,1,0: hcount advances once per two clocks and outputs hold on en=0 cycles.
REQ-035 mode_sel=3: ignored, mode_active unchanged. mode_sel=2 then rst_n pulsed low mid-frame: counters 0, mode_active=DEFAULT_MODE, no switch at the next wrap.
REQ-036 Mode 2: the frame period is 800*525=420000 cycles.

Source files
------------

// File: rtl/vga_pkg.sv
// -----------------------------------------------------------------------------
// vga_pkg
//   Shared timing types and the video mode table for vga_timing_gen.
//
//   Contents:
//     vga_timing_t   : one mode's horizontal and vertical timing. Each value is
//                      a count of pixel-clock strobes or lines, measured from
//                      the first visible pixel or line.
//     H_* / V_*      : the 1024x768 constants. The table reuses them as mode 0.
//     VGA_NUM_MODES  : number of entries in VGA_MODES.
//     VGA_MODES      : the mode table, indexed by mode number.
// -----------------------------------------------------------------------------
package vga_pkg;

    // Timing values are stored 16 bits wide. Each consumer narrows them to its
    // own counter width.
    typedef struct packed {
        logic [15:0] h_total;
        logic [15:0] h_blank_start;
        logic [15:0] h_sync_start;
        logic [15:0] h_sync_end;
        logic [15:0] v_total;
        logic [15:0] v_blank_start;
        logic [15:0] v_sync_start;
        logic [15:0] v_sync_end;
    } vga_timing_t;

    // 1024x768 timing constants, used for mode 0.
    localparam int unsigned H_TOTAL       = 1344;
    localparam int unsigned H_BLANK_START = 1024;
    localparam int unsigned H_SYNC_START  = 1048;
    localparam int unsigned H_SYNC_END    = 1184;
    localparam int unsigned V_TOTAL       = 806;
    localparam int unsigned V_BLANK_START = 768;
    localparam int unsigned V_SYNC_START  = 771;
    localparam int unsigned V_SYNC_END    = 777;

    localparam int VGA_NUM_MODES = 3;

    localparam vga_timing_t VGA_MODES [VGA_NUM_MODES] = '{
        // Mode 0: 1024x768
        '{16'(H_TOTAL), 16'(H_BLANK_START), 16'(H_SYNC_START), 16'(H_SYNC_END),
          16'(V_TOTAL), 16'(V_BLANK_START), 16'(V_SYNC_START), 16'(V_SYNC_END)},
        // Mode 1: 800x600
        '{16'd1056, 16'd800, 16'd840, 16'd968,
          16'd628,  16'd600, 16'd601, 16'd605},
        // Mode 2: 640x480
        '{16'd800,  16'd640, 16'd656, 16'd752,
          16'd525,  16'd480, 16'd490, 16'd492}
    };

endpackage : vga_pkg

// File: rtl/vga_axis_cnt.sv
// -----------------------------------------------------------------------------
// vga_axis_cnt
//   One timing axis (horizontal or vertical) of the VGA generator. It holds a
//   wrapping counter and the registered blank and sync flags for that counter
//   value. The top instantiates this module once per axis.
//
//   Ports:
//     clk, rst_n   : clock, asynchronous active-low reset
//     total        : counts per period. The counter wraps after total-1.
//     blank_start  : first blanked count value
//     sync_start   : first count value with sync asserted
//     sync_end     : first count value after sync ends (exclusive)
//     step         : advance the counter this cycle
//     count        : current count value
//     blnk         : count >= blank_start, registered with count
//     sync         : sync_start <= count < sync_end, registered with count
//     wrap         : combinational. High when this step takes count from
//                    total-1 back to 0.
// -----------------------------------------------------------------------------
module vga_axis_cnt #(
    parameter int CW = 11
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [CW-1:0] total,
    input  logic [CW-1:0] blank_start,
    input  logic [CW-1:0] sync_start,
    input  logic [CW-1:0] sync_end,
    input  logic          step,
    output logic [CW-1:0] count,
    output logic          blnk,
    output logic          sync,
    output logic          wrap
);

    logic [CW-1:0] count_q, count_d;
    logic          blnk_q,  blnk_d;
    logic          sync_q,  sync_d;

    // The flags are computed from the next count value, so they update on the
    // same edge as the counter. Each flag then describes the count it is shown
    // with, and no cycle of lag appears on the outputs.
    always_comb begin
        // NOTE: every signal gets its hold value first. This keeps the block
        // free of inferred latches when step is low.
        count_d = count_q;
        blnk_d  = blnk_q;
        sync_d  = sync_q;
        wrap    = step && (count_q == total - CW'(1));

        if (step) begin
            count_d = wrap ? '0 : count_q + CW'(1);
            blnk_d  = (count_d >= blank_start);
            sync_d  = (count_d >= sync_start) && (count_d < sync_end);
        end
    end

    // NOTE: sequential state uses non-blocking assignments only. All registers
    // here are plain flops, so every one of them gets an async reset value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            blnk_q  <= 1'b0;
            sync_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            blnk_q  <= blnk_d;
            sync_q  <= sync_d;
        end
    end

    assign count = count_q;
    assign blnk  = blnk_q;
    assign sync  = sync_q;

endmodule : vga_axis_cnt

// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
//   A multi-mode VGA timing generator. It produces the pixel and line
//   counters, active-high sync pulses, blanking flags and a start-of-frame
//   strobe. A requested mode is latched into a pending register and becomes
//   active only at a frame boundary, so no frame is ever cut short or
//   stretched.
//
//   Parameters:
//     CW           : counter width. It must hold every mode's total minus 1.
//     NUM_MODES    : number of entries in MODE_TABLE
//     DEFAULT_MODE : mode index loaded on reset
//     MODE_TABLE   : the timing table. The default is vga_pkg::VGA_MODES.
//
//   Ports:
//     clk          : pixel clock
//     rst_n        : asynchronous active-low reset
//     en           : pixel strobe. State advances only when en=1.
//     mode_sel     : requested mode index. Values >= NUM_MODES are ignored.
//     hcount       : current pixel column
//     vcount       : current line
//     hsync/vsync  : sync pulses, active high
//     hblnk/vblnk  : blanking flags
//     frame_start  : high for the one enabled cycle that shows (0,0) after a
//                    frame wrap
//     mode_active  : mode index currently driving the counters
// -----------------------------------------------------------------------------
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int          CW           = 11,
    parameter int          NUM_MODES    = 3,
    parameter int          DEFAULT_MODE = 0,
    parameter vga_timing_t MODE_TABLE [NUM_MODES] = VGA_MODES
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic [1:0]    mode_sel,
    output logic [CW-1:0] hcount,
    output logic [CW-1:0] vcount,
    output logic          hsync,
    output logic          vsync,
    output logic          hblnk,
    output logic          vblnk,
    output logic          frame_start,
    output logic [1:0]    mode_active
);

    localparam logic [1:0] RST_MODE = 2'(DEFAULT_MODE);

    // Mode control state
    logic [1:0]  mode_q, mode_d;   // active mode
    logic [1:0]  pend_q, pend_d;   // last valid request seen this frame
    logic        fs_q,   fs_d;     // a frame wrap has happened and no enabled cycle has consumed it yet

    logic        h_wrap, v_wrap;
    logic        sel_valid;
    vga_timing_t cur;

    // Timing of the active mode. The mode changes only on the edge that
    // returns both counters to 0. No valid mode is blanked or in sync at count
    // 0, so flags computed on that edge from the outgoing mode's values are
    // already correct for the incoming mode.
    assign cur = MODE_TABLE[mode_q];

    vga_axis_cnt #(.CW(CW)) u_h_cnt (
        .clk         (clk),
        .rst_n       (rst_n),
        .total       (CW'(cur.h_total)),
        .blank_start (CW'(cur.h_blank_start)),
        .sync_start  (CW'(cur.h_sync_start)),
        .sync_end    (CW'(cur.h_sync_end)),
        .step        (en),
        .count       (hcount),
        .blnk        (hblnk),
        .sync        (hsync),
        .wrap        (h_wrap)
    );

    // The vertical axis steps once per line, on the horizontal wrap.
    vga_axis_cnt #(.CW(CW)) u_v_cnt (
        .clk         (clk),
        .rst_n       (rst_n),
        .total       (CW'(cur.v_total)),
        .blank_start (CW'(cur.v_blank_start)),
        .sync_start  (CW'(cur.v_sync_start)),
        .sync_end    (CW'(cur.v_sync_end)),
        .step        (h_wrap),
        .count       (vcount),
        .blnk        (vblnk),
        .sync        (vsync),
        .wrap        (v_wrap)
    );

    assign sel_valid = (32'(mode_sel) < NUM_MODES);

    always_comb begin
        pend_d = pend_q;
        mode_d = mode_q;
        fs_d   = fs_q;

        // Out-of-range requests leave the pending mode unchanged, so the last
        // valid request in a frame wins.
        if (en && sel_valid) begin
            pend_d = mode_sel;
        end

        // On the wrap edge, the mode takes the value pending before this
        // cycle. A request sampled on the wrap cycle itself stays pending
        // until the next wrap. A request equal to the active mode reloads the
        // same value and has no effect.
        if (v_wrap) begin
            mode_d = pend_q;
        end

        // Set on the wrap edge. Cleared by the next enabled edge, which also
        // moves the counters off (0,0).
        if (en) begin
            fs_d = v_wrap;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q <= RST_MODE;
            pend_q <= RST_MODE;
            fs_q   <= 1'b0;
        end else begin
            mode_q <= mode_d;
            pend_q <= pend_d;
            fs_q   <= fs_d;
        end
    end

    // frame_start is gated by en, so it reads 0 on stalled cycles and marks
    // exactly one enabled cycle at (0,0). fs_q resets low, so no pulse appears
    // when reset is released.
    assign frame_start = fs_q & en;
    assign mode_active = mode_q;

endmodule : vga_timing_gen

// File: tb/tb_vga_timing_gen.sv
// -----------------------------------------------------------------------------
// tb_vga_timing_gen
//   Directed bench for vga_timing_gen. One instance uses the production mode
//   table for line-level timing. A second instance shares the same inputs but
//   uses a miniature table, so that frame wraps and mode switches occur
//   within a short run.
//
//   Miniature table (total/blank/sync start/sync end):
//     mode 0: H 12/8/9/11  V 6/4/4/5  -> 72-cycle frame
//     mode 1: H 10/7/8/9   V 5/3/3/4  -> 50-cycle frame
//     mode 2: H 8/6/6/7    V 4/3/3/4  -> 32-cycle frame
// -----------------------------------------------------------------------------
module tb_vga_timing_gen;
    import vga_pkg::*;

    localparam int CW = 11;

    localparam vga_timing_t SMALL_MODES [3] = '{
        '{16'd12, 16'd8, 16'd9, 16'd11, 16'd6, 16'd4, 16'd4, 16'd5},
        '{16'd10, 16'd7, 16'd8, 16'd9,  16'd5, 16'd3, 16'd3, 16'd4},
        '{16'd8,  16'd6, 16'd6, 16'd7,  16'd4, 16'd3, 16'd3, 16'd4}
    };

    logic          clk = 1'b0;
    logic          rst_n;
    logic          en;
    logic [1:0]    mode_sel;

    logic [CW-1:0] b_hcount, b_vcount, s_hcount, s_vcount;
    logic          b_hsync, b_vsync, b_hblnk, b_vblnk, b_fs;
    logic          s_hsync, s_vsync, s_hblnk, s_vblnk, s_fs;
    logic [1:0]    b_mode, s_mode;

    int n_cmp = 0;
    int n_err = 0;
    int k     = 0;   // enabled edges since the last reset release

    always #5 clk = ~clk;

    vga_timing_gen #(.CW(CW)) dut_big (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .mode_sel    (mode_sel),
        .hcount      (b_hcount),
        .vcount      (b_vcount),
        .hsync       (b_hsync),
        .vsync       (b_vsync),
        .hblnk       (b_hblnk),
        .vblnk       (b_vblnk),
        .frame_start (b_fs),
        .mode_active (b_mode)
    );

    vga_timing_gen #(.CW(CW), .NUM_MODES(3), .DEFAULT_MODE(0), .MODE_TABLE(SMALL_MODES)) dut_small (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .mode_sel    (mode_sel),
        .hcount      (s_hcount),
        .vcount      (s_vcount),
        .hsync       (s_hsync),
        .vsync       (s_vsync),
        .hblnk       (s_hblnk),
        .vblnk       (s_vblnk),
        .frame_start (s_fs),
        .mode_active (s_mode)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance with en=1 until k enabled edges have elapsed since release.
    // Outputs are sampled on the falling edge.
    task automatic adv(input int target);
        while (k < target) begin
            @(negedge clk);
            k++;
        end
    endtask

    task automatic stall_step();
        en = 1'b0;
        @(negedge clk);
    endtask

    task automatic run_step();
        en = 1'b1;
        @(negedge clk);
        k++;
    endtask

    task automatic release_reset();
        rst_n = 1'b1;
        k     = 0;
    endtask

    // Watchdog: the directed sequence is a few thousand cycles long.
    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // ---------------- Reset state (en high, to show that en is ignored) ---
        rst_n    = 1'b0;
        en       = 1'b1;
        mode_sel = 2'd0;
        repeat (3) @(negedge clk);
        check("rst_hcount", 32'(b_hcount), 0);
        check("rst_vcount", 32'(b_vcount), 0);
        check("rst_hsync",  32'(b_hsync),  0);
        check("rst_vsync",  32'(b_vsync),  0);
        check("rst_hblnk",  32'(b_hblnk),  0);
        check("rst_vblnk",  32'(b_vblnk),  0);
        check("rst_fs",     32'(b_fs),     0);
        check("rst_mode",   32'(b_mode),   0);

        // ---------------- Mode 0, production table: line timing --------------
        release_reset();
        adv(1);
        check("first_hcount", 32'(b_hcount), 1);
        check("first_vcount", 32'(b_vcount), 0);
        check("first_fs",     32'(b_fs),     0);

        // Stall test around the horizontal blank edge. Outputs must hold while
        // en=0.
        adv(1022);
        check("h1022_hcount", 32'(b_hcount), 1022);
        stall_step();
        check("stall0_hcount", 32'(b_hcount), 1022);
        check("stall0_fs",     32'(b_fs),     0);
        run_step();
        check("run1_hcount",   32'(b_hcount), 1023);
        check("run1_hblnk",    32'(b_hblnk),  0);
        stall_step();
        check("stall1_hcount", 32'(b_hcount), 1023);
        run_step();
        check("run2_hcount",   32'(b_hcount), 1024);
        check("h1024_hblnk",   32'(b_hblnk),  1);
        stall_step();
        check("stall2_hcount", 32'(b_hcount), 1024);
        check("stall2_hblnk",  32'(b_hblnk),  1);
        check("stall2_vcount", 32'(b_vcount), 0);
        en = 1'b1;

        adv(1047);
        check("h1047_hsync", 32'(b_hsync), 0);
        adv(1048);
        check("h1048_hsync", 32'(b_hsync), 1);
        adv(1183);
        check("h1183_hsync", 32'(b_hsync), 1);
        adv(1184);
        check("h1184_hsync", 32'(b_hsync), 0);
        adv(1343);
        check("h1343_hcount", 32'(b_hcount), 1343);
        check("h1343_vcount", 32'(b_vcount), 0);
        adv(1344);
        check("line_hcount", 32'(b_hcount), 0);
        check("line_vcount", 32'(b_vcount), 1);
        check("line_hblnk",  32'(b_hblnk),  0);
        check("line_vblnk",  32'(b_vblnk),  0);
        check("line_fs",     32'(b_fs),     0);

        // ---------------- Miniature table: frame timing in mode 0 ------------
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        release_reset();
        adv(1);
        check("s_first_fs", 32'(s_fs), 0);
        adv(50);   // hcount 2, vcount 4
        check("s_m0_vsync", 32'(s_vsync), 1);
        check("s_m0_vblnk", 32'(s_vblnk), 1);
        adv(57);   // hcount 9, vcount 4
        check("s_m0_hsync", 32'(s_hsync), 1);
        adv(71);
        check("s_m0_end_h", 32'(s_hcount), 11);
        check("s_m0_end_v", 32'(s_vcount), 5);
        check("s_m0_end_vsync", 32'(s_vsync), 0);
        check("s_m0_end_fs", 32'(s_fs), 0);
        adv(72);
        check("s_wrap1_h",  32'(s_hcount), 0);
        check("s_wrap1_v",  32'(s_vcount), 0);
        check("s_wrap1_fs", 32'(s_fs), 1);
        check("s_wrap1_vblnk", 32'(s_vblnk), 0);
        adv(73);
        check("s_after_fs", 32'(s_fs), 0);

        // ---------------- Mid-frame switch; the last valid request wins ------
        adv(100);
        mode_sel = 2'd2;
        adv(105);
        mode_sel = 2'd3;          // invalid, ignored
        adv(110);
        mode_sel = 2'd1;
        adv(115);
        mode_sel = 2'd3;          // invalid, so pending stays 1
        adv(120);
        check("s_mid_mode", 32'(s_mode), 0);
        check("b_sel3_mode", 32'(b_mode), 0);
        adv(143);
        check("s_old_end_h", 32'(s_hcount), 11);
        check("s_old_end_v", 32'(s_vcount), 5);
        adv(144);
        check("s_sw_fs",   32'(s_fs),   1);
        check("s_sw_mode", 32'(s_mode), 1);
        check("s_sw_h",    32'(s_hcount), 0);
        adv(152);                 // mode 1: hcount 8, vcount 0
        check("s_m1_hsync", 32'(s_hsync), 1);
        check("s_m1_hblnk", 32'(s_hblnk), 1);
        adv(175);                 // hcount 1, vcount 3
        check("s_m1_vsync", 32'(s_vsync), 1);
        adv(193);
        check("s_m1_end_h",  32'(s_hcount), 9);
        check("s_m1_end_v",  32'(s_vcount), 4);
        check("s_m1_end_fs", 32'(s_fs), 0);

        // A request sampled on the wrap cycle itself waits one more frame.
        mode_sel = 2'd2;
        adv(194);
        mode_sel = 2'd3;
        check("s_wrapreq_fs",   32'(s_fs),   1);
        check("s_wrapreq_mode", 32'(s_mode), 1);
        adv(243);
        check("s_m1b_fs", 32'(s_fs), 0);
        adv(244);
        check("s_m2_fs",   32'(s_fs),   1);
        check("s_m2_mode", 32'(s_mode), 2);
        adv(275);
        check("s_m2_end_h", 32'(s_hcount), 7);
        check("s_m2_end_v", 32'(s_vcount), 3);
        check("s_m2_vsync", 32'(s_vsync), 1);
        adv(276);
        check("s_m2_wrap_fs", 32'(s_fs), 1);
        check("s_m2_keep",    32'(s_mode), 2);

        // ---------------- Reset mid-frame discards a pending request ---------
        adv(280);
        mode_sel = 2'd1;
        adv(283);
        rst_n    = 1'b0;
        mode_sel = 2'd3;
        repeat (2) @(negedge clk);
        check("s_rst_h",     32'(s_hcount), 0);
        check("s_rst_v",     32'(s_vcount), 0);
        check("s_rst_mode",  32'(s_mode),   0);
        check("s_rst_hblnk", 32'(s_hblnk),  0);
        release_reset();
        adv(71);
        check("s_post_end_h", 32'(s_hcount), 11);
        adv(72);
        check("s_post_fs",   32'(s_fs),   1);
        check("s_post_mode", 32'(s_mode), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_vga_timing_gen
